// File: rtl/lifo_reverse_ctrl.sv
// lifo_reverse_ctrl: frame reverser that drives a LIFObuffer from a valid/ready stream
// Ports: Clk/Rst (sync active-high); in_* upstream stream; out_* reversed stream;
// lifo_* to/from LIFObuffer (RW 0=push 1=pop); err sticky flag mismatch.
// Optional LIFO_REVERSE_CTRL_FLAGCHK_EN: checks lifo_EMPTY/lifo_FULL against
// the internal occupancy; otherwise err is tied 0.
module lifo_reverse_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lifo_dataIn,
  output logic             lifo_RW,
  output logic             lifo_EN,
  input  logic [WIDTH-1:0] lifo_dataOut,
  input  logic             lifo_EMPTY,
  input  logic             lifo_FULL,
  output logic             err
);
  typedef enum logic {FILL, DRAIN} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             seg_last_q, seg_last_d;
  logic             fly_q, fly_last_q;
  logic [1:0]       occ_q, occ_d, wpos;
  logic [WIDTH:0]   sk_q [2];
  logic [WIDTH:0]   sk_d [2];
  logic             push, pop, rd;
  logic [2:0]       eff;
  assign out_valid = occ_q != 2'd0;
  assign out_data  = sk_q[0][WIDTH-1:0];
  assign out_last  = out_valid && sk_q[0][WIDTH];
  assign rd        = out_valid && out_ready;
  always_comb begin
    in_ready    = !Rst && state_q == FILL && count_q < CW'(DEPTH);
    push        = in_ready && in_valid;
    // the word leaving this cycle frees its slot, which keeps one pop per cycle
    eff         = {1'b0, occ_q} - {2'b0, rd} + {2'b0, fly_q};
    pop         = !Rst && state_q == DRAIN && count_q != '0 && eff < 3'd2;
    lifo_EN     = push || pop;
    lifo_RW     = pop;
    lifo_dataIn = push ? in_data : '0;
    count_d     = push ? count_q + 1'b1 : pop ? count_q - 1'b1 : count_q;
    state_d     = state_q;
    seg_last_d  = seg_last_q;
    if (push && (in_last || count_q == CW'(DEPTH - 1))) begin
      state_d    = DRAIN;
      seg_last_d = in_last;
    end
    if (state_q == DRAIN && count_q == '0 && !fly_q && occ_q == 2'd0) state_d = FILL;
    wpos  = occ_q - {1'b0, rd};
    occ_d = occ_q - {1'b0, rd} + {1'b0, fly_q};
    sk_d  = sk_q;
    if (rd) sk_d[0] = sk_q[1];
    if (fly_q) sk_d[wpos[0]] = {fly_last_q, lifo_dataOut};
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= FILL;
      count_q    <= '0;
      seg_last_q <= 1'b0;
      fly_q      <= 1'b0;
      fly_last_q <= 1'b0;
      occ_q      <= 2'd0;
      sk_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      seg_last_q <= seg_last_d;
      fly_q      <= pop;
      fly_last_q <= pop && count_q == CW'(1) && seg_last_q;
      occ_q      <= occ_d;
      sk_q       <= sk_d;
    end
  end
`ifdef LIFO_REVERSE_CTRL_FLAGCHK_EN
  logic exp_empty_q, exp_full_q, err_q;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      exp_empty_q <= 1'b1;
      exp_full_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      exp_empty_q <= count_q == '0;
      exp_full_q  <= count_q == CW'(DEPTH);
      if (exp_empty_q != lifo_EMPTY || exp_full_q != lifo_FULL) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_flags;
  assign unused_flags = lifo_EMPTY | lifo_FULL;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lifo_reverse_ctrl.sv
// tb_lifo_reverse_ctrl: randomized bench for lifo_reverse_ctrl with a LIFObuffer model
module tb_lifo_reverse_ctrl;
  localparam int W = 4;
  localparam int D = 8;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [W-1:0] out_data;
  logic out_valid, out_last;
  logic out_ready = 1'b1;
  logic [W-1:0] lifo_dataIn, lifo_dataOut;
  logic lifo_RW, lifo_EN, lifo_EMPTY, lifo_FULL, err;
  logic corrupt = 1'b0;
  int checks = 0, fails = 0, out_cnt = 0, mode = 0, viol = 0;
  logic [W:0] exp_q[$];
  always #5 clk = ~clk;
  lifo_reverse_ctrl #(.WIDTH(W), .DEPTH(D), .CW(C)) dut (
    .Clk(clk), .Rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .lifo_dataIn(lifo_dataIn), .lifo_RW(lifo_RW), .lifo_EN(lifo_EN),
    .lifo_dataOut(lifo_dataOut), .lifo_EMPTY(lifo_EMPTY), .lifo_FULL(lifo_FULL), .err(err)
  );
  logic [W-1:0] mem [D];
  int sp = 0;
  logic m_empty = 1'b1, m_full = 1'b0;
  logic [W-1:0] m_dout = '0;
  assign lifo_dataOut = m_dout;
  assign lifo_EMPTY   = m_empty & ~corrupt;
  assign lifo_FULL    = m_full;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      m_empty <= 1'b1;
      m_full <= 1'b0;
    end else begin
      m_empty <= (sp == 0);
      m_full <= (sp == D);
      if (lifo_EN && !lifo_RW) begin
        if (sp >= D) viol <= viol + 1;
        else begin
          mem[sp] <= lifo_dataIn;
          sp <= sp + 1;
        end
      end
      if (lifo_EN && lifo_RW) begin
        if (sp == 0) viol <= viol + 1;
        else begin
          m_dout <= mem[sp-1];
          sp <= sp - 1;
        end
      end
    end
  end
  initial begin
    int pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (pidx % 3 == 0);
      pidx++;
    end
  end
  initial begin
    logic stall = 1'b0;
    logic [W:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (stall) begin
          checks++;
          if (!out_valid || {out_last, out_data} !== held) begin
            fails++;
            $display("FAIL hold: got valid=%0b word=%h required valid=1 word=%h", out_valid, {out_last, out_data}, held);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL out_word: got %h required none (unexpected word)", {out_last, out_data});
          end else begin
            if ({out_last, out_data} !== exp_q[0]) begin
              fails++;
              $display("FAIL out_word: got last=%0b data=%0d required last=%0b data=%0d", out_last, out_data, exp_q[0][W], exp_q[0][W-1:0]);
            end
            void'(exp_q.pop_front());
          end
          out_cnt++;
        end
        stall = out_valid && !out_ready;
        held = {out_last, out_data};
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [W-1:0] f[$], input bit gaps);
    int n = f.size();
    for (int s = 0; s < n; s += D) begin
      int seg = (n - s < D) ? n - s : D;
      for (int j = seg - 1; j >= 0; j--) exp_q.push_back({(s + seg == n) && (j == 0), f[s+j]});
    end
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data = f[i];
      in_last = (i == n - 1);
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        checks++;
        fails++;
        $display("FAIL push_timeout: got in_ready=0 required 1 within 200 cycles");
      end
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_idle;
    bit ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && in_ready && !out_valid;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL idle_timeout: got pending=%0d in_ready=%0b required 0 pending and in_ready=1", exp_q.size(), in_ready);
    end
    step();
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      if (lifo_EN !== 1'b0) begin fails++; $display("FAIL rst_lifo_en: got %b required 0", lifo_EN); end
    end
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready: got %b required 1", in_ready); end
    if (err !== 1'b0) begin fails++; $display("FAIL rel_err: got %b required 0", err); end
    step();
  endtask
  task automatic test_basic;
    int nv = 0, gaps = 0, busy = 0;
    mode = 0;
    send_frame('{4'd0, 4'd2, 4'd4, 4'd6}, 1'b0);
    for (int t = 0; t < 40 && nv < 4; t++) begin
      @(negedge clk);
      if (in_ready) busy++;
      if (out_valid) nv++;
      else if (nv > 0) gaps++;
    end
    checks += 3;
    if (nv != 4) begin fails++; $display("FAIL basic_count: got %0d words required 4", nv); end
    if (gaps != 0) begin fails++; $display("FAIL basic_gaps: got %0d idle cycles required 0", gaps); end
    if (busy != 0) begin fails++; $display("FAIL basic_in_ready: got %0d ready cycles in drain required 0", busy); end
    wait_idle();
  endtask
  task automatic test_backpressure;
    mode = 2;
    send_frame('{4'd0, 4'd2, 4'd4, 4'd6}, 1'b0);
    wait_idle();
    mode = 0;
  endtask
  task automatic test_overflow;
    logic [W-1:0] f[$];
    mode = 0;
    for (int i = 1; i <= 10; i++) f.push_back(W'(i));
    send_frame(f, 1'b0);
    wait_idle();
  endtask
  task automatic test_reset_mid_drain;
    int base;
    mode = 0;
    send_frame('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 1'b0);
    base = out_cnt;
    for (int t = 0; t < 50 && out_cnt < base + 2; t++) step();
    rst = 1'b1;
    step();
    exp_q.delete();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
    if (out_last !== 1'b0) begin fails++; $display("FAIL mid_out_last: got %b required 0", out_last); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    step();
    rst = 1'b0;
    step();
    send_frame('{4'd3, 4'd5}, 1'b0);
    wait_idle();
  endtask
  task automatic test_random;
    logic [W-1:0] f[$];
    mode = 1;
    for (int k = 0; k < 8; k++) begin
      int n = $urandom_range(1, 20);
      f.delete();
      for (int i = 0; i < n; i++) f.push_back(W'($urandom_range(0, 15)));
      send_frame(f, 1'b1);
    end
    wait_idle();
    mode = 0;
  endtask
  task automatic test_flagchk;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clean: got %b required 0", err); end
    step();
    corrupt = 1'b1;
    step();
    corrupt = 1'b0;
    @(negedge clk);
`ifdef LIFO_REVERSE_CTRL_FLAGCHK_EN
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set: got %b required 1", err); end
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_hold: got %b required 1", err); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", err); end
`else
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_tied: got %b required 0", err); end
`endif
    step();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_random();
    test_flagchk();
    checks += 2;
    if (viol != 0) begin fails++; $display("FAIL lifo_bounds: got %0d bad ops required 0", viol); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL leftover: got %0d words pending required 0", exp_q.size()); end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
